// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA timing generator and its helpers.
// Defaults describe 640x480@60 with a 25 MHz pixel clock.
package vga_pkg;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned PIX_W = 16;
    localparam int unsigned FC_W  = 16;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // MSB position of each field inside an RGB565 word
    localparam int unsigned RGB_R_MSB = 15;
    localparam int unsigned RGB_G_MSB = 10;
    localparam int unsigned RGB_B_MSB = 4;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_BARS  = 2'b01,
        MODE_SOLID = 2'b10,
        MODE_BLACK = 2'b11
    } mode_e;

endpackage

// File: rtl/vga_timing_gen_rgb565_unpack.sv
// Combinational RGB565 unpacker: optional byte swap, then keeps the top
// COLOR_BITS of each channel.
module rgb565_unpack
    import vga_pkg::*;
#(
    parameter bit          BYTE_SWAP  = 1'b1,
    parameter int unsigned COLOR_BITS = 4
) (
    input  logic [PIX_W-1:0]      rgb_in,
    output logic [COLOR_BITS-1:0] red_c,
    output logic [COLOR_BITS-1:0] green_c,
    output logic [COLOR_BITS-1:0] blue_c
);

    logic [PIX_W-1:0] p;
    logic             unused_low_bits;

    always_comb begin
        p       = BYTE_SWAP ? {rgb_in[7:0], rgb_in[15:8]} : rgb_in;
        red_c   = p[RGB_R_MSB -: COLOR_BITS];
        green_c = p[RGB_G_MSB -: COLOR_BITS];
        blue_c  = p[RGB_B_MSB -: COLOR_BITS];
    end

    // Low-order channel bits are intentionally dropped when COLOR_BITS < 5.
    assign unused_low_bits = ^p;

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA timing generator: counters, syncs, data enable, row-buffer
// pacing pulses, frame counter and pixel source selection.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
    parameter int unsigned H_FP         = DEF_H_FP,
    parameter int unsigned H_SYNC       = DEF_H_SYNC,
    parameter int unsigned H_BP         = DEF_H_BP,
    parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
    parameter int unsigned V_FP         = DEF_V_FP,
    parameter int unsigned V_SYNC       = DEF_V_SYNC,
    parameter int unsigned V_BP         = DEF_V_BP,
    parameter bit          HSYNC_POL    = 1'b0,
    parameter bit          VSYNC_POL    = 1'b0,
    parameter int unsigned FRAME_LEAD   = 2,
    parameter int unsigned ROW_LEAD_POS = H_ACTIVE - 1,
    parameter int unsigned COLOR_BITS   = 4,
    parameter bit          BYTE_SWAP    = 1'b1
) (
    input  logic                  clk_25M,
    input  logic                  rst_25M,
    input  logic [PIX_W-1:0]      pixel_data,
    input  logic [1:0]            mode,
    input  logic [PIX_W-1:0]      solid_rgb,
    output logic [CNT_W-1:0]      h_counter,
    output logic [CNT_W-1:0]      v_counter,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [COLOR_BITS-1:0] red,
    output logic [COLOR_BITS-1:0] green,
    output logic [COLOR_BITS-1:0] blue,
    output logic                  start_frame,
    output logic                  start_row,
    output logic [FC_W-1:0]       frame_count
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned SF_LINE  = V_TOTAL - FRAME_LEAD;
    localparam int unsigned BAR_W    = CNT_W + 3;
    localparam logic [COLOR_BITS-1:0] FULL = '1;

    mode_e mode_q;

    logic                  h_last;
    logic                  v_last;
    logic                  frame_end;
    logic                  de_nx;
    logic                  hsync_nx;
    logic                  vsync_nx;
    logic                  sf_nx;
    logic                  sr_nx;
    logic [2:0]            bar_idx;
    logic [COLOR_BITS-1:0] pass_r, pass_g, pass_b;
    logic [COLOR_BITS-1:0] solid_r, solid_g, solid_b;
    logic [COLOR_BITS-1:0] red_nx, green_nx, blue_nx;

    rgb565_unpack #(
        .BYTE_SWAP  (BYTE_SWAP),
        .COLOR_BITS (COLOR_BITS)
    ) u_unpack_pixel (
        .rgb_in  (pixel_data),
        .red_c   (pass_r),
        .green_c (pass_g),
        .blue_c  (pass_b)
    );

    rgb565_unpack #(
        .BYTE_SWAP  (1'b0),
        .COLOR_BITS (COLOR_BITS)
    ) u_unpack_solid (
        .rgb_in  (solid_rgb),
        .red_c   (solid_r),
        .green_c (solid_g),
        .blue_c  (solid_b)
    );

    // Decode of the current counter position; registered on the next edge.
    always_comb begin
        h_last    = (h_counter == CNT_W'(H_TOTAL - 1));
        v_last    = (v_counter == CNT_W'(V_TOTAL - 1));
        frame_end = h_last && v_last;
        de_nx     = (h_counter < CNT_W'(H_ACTIVE)) && (v_counter < CNT_W'(V_ACTIVE));
        hsync_nx  = (h_counter >= CNT_W'(HS_START) && h_counter < CNT_W'(HS_END))
                    ? HSYNC_POL : ~HSYNC_POL;
        vsync_nx  = (v_counter >= CNT_W'(VS_START) && v_counter < CNT_W'(VS_END))
                    ? VSYNC_POL : ~VSYNC_POL;
        sf_nx     = (h_counter == '0) && (v_counter == CNT_W'(SF_LINE));
        sr_nx     = (h_counter == CNT_W'(ROW_LEAD_POS)) && (v_counter < CNT_W'(V_ACTIVE - 1));
        bar_idx   = 3'({h_counter, 3'b000} / BAR_W'(H_ACTIVE));
    end

    // Pixel source by latched mode; blanking forces black.
    always_comb begin
        red_nx   = '0;
        green_nx = '0;
        blue_nx  = '0;
        if (de_nx) begin
            case (mode_q)
                MODE_PASS: begin
                    red_nx   = pass_r;
                    green_nx = pass_g;
                    blue_nx  = pass_b;
                end
                MODE_BARS: begin
                    red_nx   = bar_idx[2] ? FULL : '0;
                    green_nx = bar_idx[1] ? FULL : '0;
                    blue_nx  = bar_idx[0] ? FULL : '0;
                end
                MODE_SOLID: begin
                    red_nx   = solid_r;
                    green_nx = solid_g;
                    blue_nx  = solid_b;
                end
                default: begin
                    red_nx   = '0;
                    green_nx = '0;
                    blue_nx  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_25M) begin
        if (rst_25M) begin
            h_counter   <= '0;
            v_counter   <= CNT_W'(V_ACTIVE);
            frame_count <= '0;
            mode_q      <= MODE_BLACK;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            de          <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            start_frame <= 1'b0;
            start_row   <= 1'b0;
        end else begin
            h_counter <= h_last ? '0 : h_counter + CNT_W'(1);
            if (h_last) begin
                v_counter <= v_last ? '0 : v_counter + CNT_W'(1);
            end
            // Mode is only taken at the frame wrap so a frame never tears.
            if (frame_end) begin
                frame_count <= frame_count + FC_W'(1);
                mode_q      <= mode_e'(mode);
            end
            hsync       <= hsync_nx;
            vsync       <= vsync_nx;
            de          <= de_nx;
            red         <= red_nx;
            green       <= green_nx;
            blue        <= blue_nx;
            start_frame <= sf_nx;
            start_row   <= sr_nx;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a reduced timing (80x31 totals)
// so that several full frames fit in a short run.
module tb_vga_timing_gen;

    localparam int H_ACTIVE = 64;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 8;
    localparam int H_BP     = 4;
    localparam int H_TOTAL  = 80;
    localparam int V_ACTIVE = 24;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int V_TOTAL  = 31;
    localparam int FRAME_CYC = H_TOTAL * V_TOTAL;

    logic        clk_25M = 1'b0;
    logic        rst_25M = 1'b1;
    logic [15:0] pixel_data = 16'h1FF8;
    logic [1:0]  mode = 2'b00;
    logic [15:0] solid_rgb = 16'h0000;
    logic [9:0]  h_counter, v_counter;
    logic        hsync, vsync, de, start_frame, start_row;
    logic [3:0]  red, green, blue;
    logic [15:0] frame_count;

    int tests = 0;
    int fails = 0;
    int mh = 0, mv = 0, ph = 0, pv = 0;

    always #20 clk_25M = ~clk_25M;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .FRAME_LEAD(2),
        .ROW_LEAD_POS(H_ACTIVE - 1), .COLOR_BITS(4), .BYTE_SWAP(1'b1)
    ) dut (
        .clk_25M(clk_25M), .rst_25M(rst_25M), .pixel_data(pixel_data),
        .mode(mode), .solid_rgb(solid_rgb), .h_counter(h_counter),
        .v_counter(v_counter), .hsync(hsync), .vsync(vsync), .de(de),
        .red(red), .green(green), .blue(blue), .start_frame(start_frame),
        .start_row(start_row), .frame_count(frame_count)
    );

    // Advance one clock; (mh,mv) is the expected counter position after the
    // edge and (ph,pv) the position the registered outputs now decode.
    task automatic tick();
        ph = mh;
        pv = mv;
        if (rst_25M) begin
            mh = 0;
            mv = V_ACTIVE;
        end else if (mh == H_TOTAL - 1) begin
            mh = 0;
            mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
        end else begin
            mh = mh + 1;
        end
        @(negedge clk_25M);
    endtask

    task automatic run_until(input int th, input int tv, input bit chk,
                             input logic [11:0] want, output int errs);
        int n;
        logic [11:0] exp_rgb;
        errs = 0;
        n = 0;
        do begin
            tick();
            n++;
            exp_rgb = (ph < H_ACTIVE && pv < V_ACTIVE) ? want : 12'h000;
            if (chk && {red, green, blue} !== exp_rgb) errs++;
        end while (!(mh == th && mv == tv) && n <= FRAME_CYC);
        tests++;
        if (!(mh == th && mv == tv)) begin
            fails++;
            $display("FAIL run_until h=%0d v=%0d not reached, at h=%0d v=%0d", th, tv, mh, mv);
        end
    endtask

    task automatic do_reset();
        rst_25M = 1'b1;
        tick();
        rst_25M = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        tests++;
        if (h_counter !== 10'd0 || v_counter !== 10'd24) begin
            fails++;
            $display("FAIL %s_counters got h=%0d v=%0d want h=0 v=24", tag, h_counter, v_counter);
        end
        tests++;
        if (hsync !== 1'b1 || vsync !== 1'b1 || de !== 1'b0) begin
            fails++;
            $display("FAIL %s_sync_de got hs=%b vs=%b de=%b want 1 1 0", tag, hsync, vsync, de);
        end
        tests++;
        if ({red, green, blue} !== 12'h000) begin
            fails++;
            $display("FAIL %s_rgb got %h want 000", tag, {red, green, blue});
        end
        tests++;
        if (start_frame !== 1'b0 || start_row !== 1'b0 || frame_count !== 16'd0) begin
            fails++;
            $display("FAIL %s_pulses got sf=%b sr=%b fc=%0d want 0 0 0", tag, start_frame, start_row, frame_count);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_values("reset");
    endtask

    // Two frames from reset: 38 full lines, sync/de/pulse counts.
    task automatic test_timing();
        int cnt_err = 0, hs_low = 0, vs_low = 0, line_hs = 0, line_err = 0;
        int de_hi = 0, sf_n = 0, sf_pos_err = 0, sr_n = 0, sr_h = -1, sr_v = -1;
        for (int t = 0; t < 3040; t++) begin
            tick();
            if (h_counter !== 10'(mh) || v_counter !== 10'(mv)) cnt_err++;
            if (hsync === 1'b0) begin hs_low++; line_hs++; end
            if (ph == H_TOTAL - 1) begin
                if (line_hs != H_SYNC) line_err++;
                line_hs = 0;
            end
            if (vsync === 1'b0) vs_low++;
            if (de === 1'b1) de_hi++;
            if (start_frame === 1'b1) begin
                sf_n++;
                if (ph != 0 || pv != 29) sf_pos_err++;
            end
            if (start_row === 1'b1) begin sr_n++; sr_h = ph; sr_v = pv; end
        end
        tests++;
        if (cnt_err != 0) begin fails++; $display("FAIL counters got %0d bad cycles want 0", cnt_err); end
        tests++;
        if (hs_low != 304 || line_err != 0) begin
            fails++; $display("FAIL hsync_low got %0d (bad lines %0d) want 304 (0)", hs_low, line_err);
        end
        tests++;
        if (vs_low != 320) begin fails++; $display("FAIL vsync_low got %0d want 320", vs_low); end
        tests++;
        if (de_hi != 1536) begin fails++; $display("FAIL de_count got %0d want 1536", de_hi); end
        tests++;
        if (sf_n != 2 || sf_pos_err != 0) begin
            fails++; $display("FAIL start_frame got n=%0d badpos=%0d want 2 0", sf_n, sf_pos_err);
        end
        tests++;
        if (sr_n != 23 || sr_h != 63 || sr_v != 22) begin
            fails++; $display("FAIL start_row got n=%0d last h=%0d v=%0d want 23 63 22", sr_n, sr_h, sr_v);
        end
        tests++;
        if (frame_count !== 16'd2) begin fails++; $display("FAIL frame_count got %0d want 2", frame_count); end
    endtask

    // Mode 00 with 1FF8 swapped -> F81F; one injected pixel checks sampling cycle.
    task automatic test_passthrough();
        int pix_err = 0;
        logic [11:0] inj = 12'hxxx;
        logic [11:0] want;
        for (int t = 0; t < FRAME_CYC; t++) begin
            pixel_data = (mh == 10 && mv == 1) ? 16'hE007 : 16'h1FF8;
            tick();
            if (ph == 10 && pv == 1) inj = {red, green, blue};
            else begin
                want = (ph < H_ACTIVE && pv < V_ACTIVE) ? 12'hF0F : 12'h000;
                if ({red, green, blue} !== want) pix_err++;
            end
        end
        pixel_data = 16'h1FF8;
        tests++;
        if (pix_err != 0) begin fails++; $display("FAIL pass_pixels got %0d bad cycles want 0", pix_err); end
        tests++;
        if (inj !== 12'h0F0) begin fails++; $display("FAIL pass_sample got %h want 0f0", inj); end
    endtask

    task automatic test_color_bars();
        logic [11:0] bars [8] = '{12'h000, 12'h00F, 12'h0F0, 12'h0FF,
                                  12'hF00, 12'hF0F, 12'hFF0, 12'hFFF};
        logic [11:0] want, prev;
        int errs, bar_err = 0, trans = 0, trans_pos_err = 0;
        mode = 2'b01;
        run_until(0, 0, 1'b1, 12'hF0F, errs);
        tests++;
        if (errs != 0) begin fails++; $display("FAIL bars_pre_wrap got %0d bad cycles want 0", errs); end
        prev = 12'h000;
        for (int t = 0; t < H_TOTAL; t++) begin
            tick();
            want = (ph < H_ACTIVE) ? bars[ph / 8] : 12'h000;
            if ({red, green, blue} !== want) bar_err++;
            if (ph > 0 && ph < H_ACTIVE && {red, green, blue} !== prev) begin
                trans++;
                if (ph % 8 != 0) trans_pos_err++;
            end
            prev = {red, green, blue};
        end
        tests++;
        if (bar_err != 0) begin fails++; $display("FAIL bars_colour got %0d bad cycles want 0", bar_err); end
        tests++;
        if (trans != 7 || trans_pos_err != 0) begin
            fails++; $display("FAIL bars_edges got %0d (misplaced %0d) want 7 (0)", trans, trans_pos_err);
        end
    endtask

    // 00 -> 10 mid-frame must not show until the frame wrap.
    task automatic test_mode_switch();
        int errs, solid_err = 0;
        logic [11:0] want;
        mode = 2'b00;
        run_until(0, 0, 1'b0, 12'h000, errs);
        solid_rgb = 16'h07E0;
        run_until(0, 10, 1'b1, 12'hF0F, errs);
        mode = 2'b10;
        run_until(0, 0, 1'b1, 12'hF0F, errs);
        tests++;
        if (errs != 0) begin fails++; $display("FAIL switch_tear got %0d bad cycles want 0", errs); end
        for (int t = 0; t < H_TOTAL; t++) begin
            tick();
            want = (ph < H_ACTIVE) ? 12'h0F0 : 12'h000;
            if ({red, green, blue} !== want) solid_err++;
        end
        tests++;
        if (solid_err != 0) begin fails++; $display("FAIL switch_solid got %0d bad cycles want 0", solid_err); end
    endtask

    task automatic test_reset_midframe();
        int errs, n = 0;
        run_until(30, 10, 1'b1, 12'h0F0, errs);
        tests++;
        if (errs != 0) begin fails++; $display("FAIL pre_reset_solid got %0d bad cycles want 0", errs); end
        do_reset();
        check_reset_values("midreset");
        do begin
            tick();
            n++;
        end while (start_frame !== 1'b1 && n <= FRAME_CYC);
        tests++;
        if (start_frame !== 1'b1 || n != 401 || ph != 0 || pv != 29) begin
            fails++;
            $display("FAIL midreset_sf got n=%0d at h=%0d v=%0d want 401 at h=0 v=29", n, ph, pv);
        end
    endtask

    initial begin
        @(negedge clk_25M);
        test_reset();
        test_timing();
        test_passthrough();
        test_color_bars();
        test_mode_switch();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
